// File: rtl/sw_debounce_if.sv
// Switch conditioning bus: raw switch levels in, debounced levels and edge pulses out.
interface sw_debounce_if #(
    parameter int N_SW = 10
);
    logic [N_SW-1:0] sw_in;
    logic [N_SW-1:0] sw_stable;
    logic [N_SW-1:0] sw_rise;
    logic [N_SW-1:0] sw_fall;
    logic            sw_changed;

    // Board / stimulus side: drives raw switches, consumes clean levels.
    modport master (
        output sw_in,
        input  sw_stable, sw_rise, sw_fall, sw_changed
    );

    // Debouncer side.
    modport slave (
        input  sw_in,
        output sw_stable, sw_rise, sw_fall, sw_changed
    );
endinterface

// File: rtl/sw_debounce.sv
// Switch debouncer: two-flop synchroniser, per-bit stability counter,
// registered clean level plus one-cycle rise/fall pulses per switch.

// One switch lane. Accepts a new level after DEB_CYCLES consecutive
// cycles of the synchronised input disagreeing with the current level.
module sw_debounce_lane #(
    parameter int DEB_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic stable,
    output logic rise,
    output logic fall,
    output logic flip_nxt  // level accepted on the coming edge
);
    localparam int CNT_W = $clog2(DEB_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             stable_q, stable_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next-state: synchroniser shift, count disagreement, flip level at the limit.
    always_comb begin
        s1_d     = raw;
        s2_d     = s1_q;
        cnt_d    = '0;
        stable_d = stable_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        if (s2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = s2_q;
                rise_d   = s2_q;
                fall_d   = ~s2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // State registers; reset drops any partial count and the synchroniser contents.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    assign stable   = stable_q;
    assign rise     = rise_q;
    assign fall     = fall_q;
    assign flip_nxt = rise_d | fall_d;
endmodule

module sw_debounce #(
    parameter int N_SW       = 10,
    parameter int DEB_CYCLES = 50000
) (
    input logic           clk,
    input logic           reset,
    sw_debounce_if.slave  bus
);
    logic [N_SW-1:0] stable_w, rise_w, fall_w, flip_w;
    logic            sw_changed_q, sw_changed_d;

    for (genvar i = 0; i < N_SW; i++) begin : g_lane
        sw_debounce_lane #(.DEB_CYCLES(DEB_CYCLES)) u_lane (
            .clk      (clk),
            .reset    (reset),
            .raw      (bus.sw_in[i]),
            .stable   (stable_w[i]),
            .rise     (rise_w[i]),
            .fall     (fall_w[i]),
            .flip_nxt (flip_w[i])
        );
    end

    // Summary pulse lines up with the per-bit pulses by using their next-state.
    always_comb begin
        sw_changed_d = |flip_w;
    end

    // Registered summary pulse.
    always_ff @(posedge clk) begin
        if (reset) sw_changed_q <= 1'b0;
        else       sw_changed_q <= sw_changed_d;
    end

    assign bus.sw_stable  = stable_w;
    assign bus.sw_rise    = rise_w;
    assign bus.sw_fall    = fall_w;
    assign bus.sw_changed = sw_changed_q;
endmodule

// File: tb/tb_sw_debounce.sv
// Scoreboard bench for sw_debounce with DEB_CYCLES=4: each scenario pushes the
// expected output for every upcoming edge, then drives stimulus; entries are
// popped and compared on the falling edge after their rising edge.
module tb_sw_debounce;
    localparam int N = 10;
    localparam int D = 4;

    typedef struct {
        int          cyc;
        string       tag;
        logic [N-1:0] st;
        logic [N-1:0] ri;
        logic [N-1:0] fa;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   ecnt = 0;
    int   n_pass = 0;
    int   n_tot  = 0;
    exp_t sb[$];

    sw_debounce_if #(.N_SW(N)) bus ();

    sw_debounce #(.N_SW(N), .DEB_CYCLES(D)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) ecnt <= ecnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, ecnt);
    endtask

    task automatic push(input int rel, input string tag,
                        input logic [N-1:0] st, input logic [N-1:0] ri, input logic [N-1:0] fa);
        exp_t e;
        e.cyc = ecnt + rel;
        e.tag = tag;
        e.st  = st;
        e.ri  = ri;
        e.fa  = fa;
        sb.push_back(e);
    endtask

    // Expect level old -> nw on relative edge 'at', quiet elsewhere, for n edges.
    task automatic push_win(input string tag, input int n, input logic [N-1:0] old,
                            input logic [N-1:0] nw, input int at,
                            input logic [N-1:0] ri, input logic [N-1:0] fa);
        for (int c = 1; c <= n; c++)
            push(c, $sformatf("%s@%0d", tag, c), (c < at) ? old : nw,
                 (c == at) ? ri : '0, (c == at) ? fa : '0);
    endtask

    // Advance one edge and compare every entry due on it.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        while (sb.size() > 0 && sb[0].cyc <= ecnt) begin
            e = sb.pop_front();
            chk({e.tag, ".stable"},  32'(bus.sw_stable), 32'(e.st));
            chk({e.tag, ".rise"},    32'(bus.sw_rise),   32'(e.ri));
            chk({e.tag, ".fall"},    32'(bus.sw_fall),   32'(e.fa));
            chk({e.tag, ".changed"}, 32'(bus.sw_changed), 32'(|(e.ri | e.fa)));
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        reset      = 1'b1;
        bus.sw_in  = '0;
        push(1, "rst1", '0, '0, '0);
        push(2, "rst2", '0, '0, '0);
        ticks(2);
        reset = 1'b0;
        ticks(2);

        // Clean rise on bit 3: accepted D+2 edges after the drive.
        push_win("rise3", 8, '0, 10'h008, D + 2, 10'h008, '0);
        bus.sw_in[3] = 1'b1;
        ticks(8);

        // Glitch of D-1 cycles on bit 0: discarded.
        push_win("glitch", 12, 10'h008, 10'h008, 99, '0, '0);
        bus.sw_in[0] = 1'b1;
        ticks(D - 1);
        bus.sw_in[0] = 1'b0;
        ticks(12 - (D - 1));

        // Bounce on bit 5: toggle every 2 cycles, last transition (to 1) at rel 20.
        push_win("bounce", 28, 10'h008, 10'h028, 20 + D + 2, 10'h020, '0);
        for (int i = 0; i <= 20; i++) begin
            if (i % 2 == 0) bus.sw_in[5] = ~bus.sw_in[5];
            tick();
        end
        ticks(7);

        // Clear back to zero: multi-bit fall.
        push_win("clr", 8, 10'h028, '0, D + 2, '0, 10'h028);
        bus.sw_in = '0;
        ticks(8);

        // Multi-bit rise in one cycle.
        push_win("multi", 8, '0, 10'h201, D + 2, 10'h201, '0);
        bus.sw_in = 10'h201;
        ticks(8);

        // Simultaneous rise and fall on different bits.
        push_win("swap", 8, 10'h201, 10'h0F0, D + 2, 10'h0F0, 10'h201);
        bus.sw_in = 10'h0F0;
        ticks(8);

        // Fall of 0F0.
        push_win("fall", 8, 10'h0F0, '0, D + 2, '0, 10'h0F0);
        bus.sw_in = '0;
        ticks(8);

        // Bit 0 on, so reset has a nonzero level to clear.
        push_win("pre", 8, '0, 10'h001, D + 2, 10'h001, '0);
        bus.sw_in = 10'h001;
        ticks(8);

        // Reset mid-count on bit 7; bit 0 held high across reset re-rises too.
        for (int c = 1; c <= 11; c++)
            push(c, $sformatf("rstmid@%0d", c),
                 (c < 4) ? 10'h001 : (c < 10) ? 10'h000 : 10'h081,
                 (c == 10) ? 10'h081 : 10'h000, '0);
        bus.sw_in = 10'h081;
        ticks(3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ticks(7);

        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
